branch_resolve_unit: RTL

//  EX-stage counterpart of the IF-stage BTB: tracks every in-flight IF prediction in an
//  in-order queue and compares it with the EX outcome. Produces the BTB training stream
//  (set/pc/taken/target/branch_is_error) plus a one-cycle flush and redirect PC to the PC unit.

---
 rtl/branch_resolve_unit_pkg.sv | 20 ++
 rtl/branch_resolve_unit_pred_fifo.sv | 68 ++++++
 rtl/branch_resolve_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared widths, prediction entry layout and PC helper for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int ADDR_W       = 32;
  localparam int PRED_ENTRY_W = 2 * ADDR_W + 1;

  // One in-flight IF prediction: fetched PC, predicted direction, predicted target.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] target;
  } pred_entry_t;

  // Sequential fetch PC after a resolved instruction; branches skip their delay slot.
  function automatic logic [ADDR_W-1:0] next_fetch_pc(input logic [ADDR_W-1:0] pc,
                                                       input logic              is_branch);
    return pc + (is_branch ? 32'd8 : 32'd4);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-order queue of in-flight predictions with synchronous clear and a
// combinational head read. Push is ignored while full, pop while empty,
// and clear overrides both in the same cycle.
module branch_resolve_unit_pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [PRED_ENTRY_W-1:0] push_data,
  input  logic                    pop,
  input  logic                    clear,
  output logic [PRED_ENTRY_W-1:0] head,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PRED_ENTRY_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    do_push_s;
  logic                    do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolve unit: matches each resolving instruction with the
// oldest in-flight IF prediction, emits BTB training, flush/redirect on a
// misprediction, and keeps a saturating misprediction count.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int MCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid_i,
  input  logic [31:0]       pred_pc_i,
  input  logic              pred_taken_i,
  input  logic [31:0]       pred_target_i,
  output logic              pred_ready_o,
  input  logic              res_valid_i,
  input  logic [31:0]       res_pc_i,
  input  logic              res_is_branch_i,
  input  logic              res_taken_i,
  input  logic [31:0]       res_target_i,
  output logic              set_o,
  output logic [31:0]       set_pc_o,
  output logic              set_taken_o,
  output logic [31:0]       set_target_o,
  output logic              branch_error_o,
  output logic              flush_o,
  output logic [31:0]       redirect_pc_o,
  output logic [MCNT_W-1:0] mispred_cnt_o
);

  pred_entry_t       push_entry_s;
  pred_entry_t       fifo_head_s;
  pred_entry_t       head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              clear_s;
  logic              mispred_s;
  logic              set_s;
  logic              act_taken_s;
  logic [31:0]       redirect_s;

  logic              set_r;
  logic [31:0]       set_pc_r;
  logic              set_taken_r;
  logic [31:0]       set_target_r;
  logic              branch_error_r;
  logic              flush_r;
  logic [31:0]       redirect_pc_r;
  logic [MCNT_W-1:0] mispred_cnt_r;

  assign push_entry_s = '{pc: pred_pc_i, taken: pred_taken_i, target: pred_target_i};
  // A misprediction empties the queue; younger entries and any same-cycle push are wrong-path.
  assign clear_s      = res_valid_i & mispred_s;
  assign pred_ready_o = ~fifo_full_s;

  branch_resolve_unit_pred_fifo #(
    .DEPTH(QDEPTH)
  ) u_pred_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pred_valid_i),
    .push_data(push_entry_s),
    .pop      (res_valid_i),
    .clear    (clear_s),
    .head     (fifo_head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Compare the oldest prediction with the EX outcome; an empty queue means "predicted not-taken, no target".
  always_comb begin
    head_s = fifo_head_s;
    if (fifo_empty_s) begin
      head_s = '{pc: res_pc_i, taken: 1'b0, target: 32'd0};
    end else begin
      head_s = fifo_head_s;
    end
    act_taken_s = res_is_branch_i & res_taken_i;
    mispred_s   = (head_s.pc != res_pc_i)
                | (res_is_branch_i & (head_s.taken != res_taken_i))
                | (act_taken_s & head_s.taken & (head_s.target != res_target_i))
                | (~res_is_branch_i & head_s.taken);
    set_s       = res_is_branch_i | head_s.taken;
    if (act_taken_s) begin
      redirect_s = res_target_i;
    end else begin
      redirect_s = next_fetch_pc(res_pc_i, res_is_branch_i);
    end
  end

  // Register training/flush outputs one cycle after each resolve; strobes drop when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_r          <= 1'b0;
      set_pc_r       <= 32'd0;
      set_taken_r    <= 1'b0;
      set_target_r   <= 32'd0;
      branch_error_r <= 1'b0;
      flush_r        <= 1'b0;
      redirect_pc_r  <= 32'd0;
    end else if (res_valid_i) begin
      set_r          <= set_s;
      set_pc_r       <= res_pc_i;
      set_taken_r    <= act_taken_s;
      set_target_r   <= res_target_i;
      branch_error_r <= mispred_s;
      flush_r        <= mispred_s;
      redirect_pc_r  <= redirect_s;
    end else begin
      set_r          <= 1'b0;
      branch_error_r <= 1'b0;
      flush_r        <= 1'b0;
    end
  end

  // Saturating misprediction counter for performance readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt_r <= {MCNT_W{1'b0}};
    end else if (clear_s && (mispred_cnt_r != {MCNT_W{1'b1}})) begin
      mispred_cnt_r <= mispred_cnt_r + MCNT_W'(1);
    end else begin
      mispred_cnt_r <= mispred_cnt_r;
    end
  end

  assign set_o          = set_r;
  assign set_pc_o       = set_pc_r;
  assign set_taken_o    = set_taken_r;
  assign set_target_o   = set_target_r;
  assign branch_error_o = branch_error_r;
  assign flush_o        = flush_r;
  assign redirect_pc_o  = redirect_pc_r;
  assign mispred_cnt_o  = mispred_cnt_r;

endmodule
